// File: rtl/psum_accum_pkg.sv
// Shared types and constants for the partial-sum accumulator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, saturation bound helpers, counter width helper.
package psum_accum_pkg;

    typedef enum logic [1:0] {
        READ  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Largest value representable in a signed field of bw bits.
    function automatic longint sat_max(input int bw);
        return (longint'(1) <<< (bw - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a signed field of bw bits.
    function automatic longint sat_min(input int bw);
        return -(longint'(1) <<< (bw - 1));
    endfunction

    // Index width for a counter over n values; never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psum_sat_add.sv
// One accumulator lane: sign-extend a partial sum and add it to the running value with saturation.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is written.
//
// Ports:
//   psum  - signed incoming partial sum (psum_bw bits)
//   acc   - signed current accumulator value (acc_bw bits)
//   pass0 - first pass of a tile: result is the sign-extended psum, acc is ignored
//   sum   - signed result (acc_bw bits), clipped to the acc_bw signed range
module psum_sat_add
    import psum_accum_pkg::*;
#(
    parameter int psum_bw = 4,
    parameter int acc_bw  = 16
) (
    input  logic [psum_bw-1:0] psum,
    input  logic [acc_bw-1:0]  acc,
    input  logic               pass0,
    output logic [acc_bw-1:0]  sum
);

    localparam logic [acc_bw-1:0] MAX_V = acc_bw'(sat_max(acc_bw));
    localparam logic [acc_bw-1:0] MIN_V = acc_bw'(sat_min(acc_bw));

    // One guard bit is enough: a psum never exceeds the accumulator range.
    logic [acc_bw:0] psum_x;
    logic [acc_bw:0] acc_x;
    logic [acc_bw:0] raw;

    assign psum_x = {{(acc_bw + 1 - psum_bw){psum[psum_bw-1]}}, psum};
    assign acc_x  = {acc[acc_bw-1], acc};
    assign raw    = acc_x + psum_x;

    always_comb begin
        sum = raw[acc_bw-1:0];
        if (pass0) begin
            sum = psum_x[acc_bw-1:0];
        end else if (raw[acc_bw] != raw[acc_bw-1]) begin
            // Guard bit disagrees with the sign bit: clip toward the true sign.
            sum = raw[acc_bw] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/psum_accum.sv
// Accumulates n_pass kernel passes of n_out column vectors from the MAC output FIFO, then drains rows.
// Latency: one pop per RD_LAT+1 cycles; out_valid rises the cycle after the final accumulate.
// Backpressure: out/out_valid hold while out_ready is low; no FIFO pops outside READ.
//
// Optional feature macro: PSUM_ACC_RELU_EN - when defined, negative drained lanes are output as 0.
//
// Ports:
//   clk, reset       - single clock; synchronous active-low reset
//   ofifo_valid      - upstream FIFO non-empty
//   ofifo_rd         - one-cycle pop request (combinational from state and ofifo_valid)
//   in               - popped vector, col lanes of psum_bw bits, valid RD_LAT cycles after ofifo_rd
//   out, out_valid   - finished row (col lanes of acc_bw bits) and its valid
//   out_ready        - downstream accept
//   done             - one-cycle pulse after the last row of a tile is accepted
module psum_accum
    import psum_accum_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = 4,
    parameter int acc_bw  = 16,
    parameter int n_out   = 16,
    parameter int n_pass  = 9,
    parameter int RD_LAT  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ofifo_valid,
    output logic                    ofifo_rd,
    input  logic [psum_bw*col-1:0]  in,
    output logic [acc_bw*col-1:0]   out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    done
);

    localparam int RW = cnt_bits(n_out);
    localparam int PW = cnt_bits(n_pass);
    localparam int CW = cnt_bits(RD_LAT + 1);

    localparam logic [RW-1:0] R_LAST   = RW'(n_out - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(n_pass - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [RW-1:0]   r;
    logic [RW-1:0]   d;
    logic [PW-1:0]   p;

    // Not reset: pass 0 overwrites every row before it is ever read.
    logic [acc_bw*col-1:0] acc_mem [n_out];
    logic [acc_bw*col-1:0] acc_nxt;
    logic                  acc_we;

    // Reset gates the pop so nothing is requested while the block is held.
    assign ofifo_rd = reset && ofifo_valid && (state == READ);
    assign acc_we   = (state == WAIT) && (wait_cnt == CNT_ONE);

    for (genvar g = 0; g < col; g++) begin : g_lane
        psum_sat_add #(
            .psum_bw (psum_bw),
            .acc_bw  (acc_bw)
        ) u_lane (
            .psum  (in[g*psum_bw +: psum_bw]),
            .acc   (acc_mem[r][g*acc_bw +: acc_bw]),
            .pass0 (p == '0),
            .sum   (acc_nxt[g*acc_bw +: acc_bw])
        );
    end

    // A write landing on a reset edge belongs to a discarded read.
    always_ff @(posedge clk) begin
        if (reset && acc_we) begin
            acc_mem[r] <= acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= READ;
            wait_cnt  <= '0;
            r         <= '0;
            p         <= '0;
            d         <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                READ: begin
                    if (ofifo_valid) begin
                        state    <= WAIT;
                        wait_cnt <= CNT_LOAD;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - CNT_ONE;
                    if (wait_cnt == CNT_ONE) begin
                        if (r == R_LAST) begin
                            r <= '0;
                            if (p == P_LAST) begin
                                state     <= DRAIN;
                                out_valid <= 1'b1;
                            end else begin
                                p     <= p + 1'b1;
                                state <= READ;
                            end
                        end else begin
                            r     <= r + 1'b1;
                            state <= READ;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (d == R_LAST) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            d <= d + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r     <= '0;
                    p     <= '0;
                    d     <= '0;
                    state <= READ;
                end
                default: state <= READ;
            endcase
        end
    end

    // Output mux is driven only by registered state (d, out_valid), never by in.
    logic [acc_bw-1:0] lane;

    always_comb begin
        out  = '0;
        lane = '0;
        if (out_valid) begin
            for (int i = 0; i < col; i++) begin
                lane = acc_mem[d][i*acc_bw +: acc_bw];
`ifdef PSUM_ACC_RELU_EN
                if (lane[acc_bw-1]) begin
                    lane = '0;
                end
`endif
                out[i*acc_bw +: acc_bw] = lane;
            end
        end
    end

endmodule

// File: tb/tb_psum_accum.sv
// Scoreboard bench for psum_accum: a FIFO model feeds vectors, a reference model queues expected rows.
// Latency: checks exact pop spacing, out_valid rise and done pulse timing each cycle.
// Backpressure: randomized and directed out_ready stalls; a second instance covers saturation.
module tb_psum_accum;

    localparam int COL   = 8;
    localparam int PB    = 4;
    localparam int AB    = 16;
    localparam int NO    = 2;
    localparam int NP    = 3;
    localparam int RL    = 2;
    localparam int IN_W  = PB * COL;
    localparam int OUT_W = AB * COL;
    localparam int S_AB  = 6;
    localparam int S_NP  = 9;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             ofifo_valid = 1'b0;
    logic             ofifo_rd;
    logic [IN_W-1:0]  in_dat = '0;
    logic [OUT_W-1:0] out_dat;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             done;

    logic                  s_reset = 1'b0;
    logic                  s_fv = 1'b1;
    logic                  s_rd;
    logic [IN_W-1:0]       s_in = '0;
    logic [S_AB*COL-1:0]   s_out;
    logic                  s_ov;
    logic                  s_ordy = 1'b1;
    logic                  s_done;

    psum_accum #(.col(COL), .psum_bw(PB), .acc_bw(AB), .n_out(NO), .n_pass(NP), .RD_LAT(RL)) dut (
        .clk(clk), .reset(reset), .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd), .in(in_dat),
        .out(out_dat), .out_valid(out_valid), .out_ready(out_ready), .done(done)
    );

    psum_accum #(.col(COL), .psum_bw(PB), .acc_bw(S_AB), .n_out(NO), .n_pass(S_NP), .RD_LAT(RL)) dut_sat (
        .clk(clk), .reset(s_reset), .ofifo_valid(s_fv), .ofifo_rd(s_rd), .in(s_in),
        .out(s_out), .out_valid(s_ov), .out_ready(s_ordy), .done(s_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int x, input int bw);
        int lo, hi;
        lo = -(1 << (bw - 1));
        hi = (1 << (bw - 1)) - 1;
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    function automatic int relu(input int x);
`ifdef PSUM_ACC_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    // Testbench model state
    logic [IN_W-1:0]  fifo_q [$];
    logic [OUT_W-1:0] exp_q  [$];
    logic [IN_W-1:0]  pend_dat = '0;
    int pend = -1;          // cycles until the popped vector must be on in; <0 means nothing in flight
    int pops = 0;           // pops taken in the current tile
    bit closed = 0;         // all pops of the tile taken, waiting for drain/done
    bit drained = 0;        // all rows of the tile accepted
    bit done_exp = 0;
    int rows = 0;
    int tiles_done = 0;
    int rst_req = 3;
    bit rst_seen = 0;
    int valid_pct = 100;
    int ready_pct = 100;
    int bp_left = 0;
    bit sat_fin = 0;

    // Mode 0: every lane a; mode 1: even lanes a, odd lanes b; mode 2: random lanes.
    task automatic push_tile(input int mode, input int a, input int b);
        int acc [NO][COL];
        int val;
        logic [IN_W-1:0]  v;
        logic [OUT_W-1:0] o;
        for (int k = 0; k < NO * NP; k++) begin
            for (int i = 0; i < COL; i++) begin
                if (mode == 0)      val = a;
                else if (mode == 1) val = (i % 2 == 0) ? a : b;
                else                val = int'($urandom_range(15)) - 8;
                v[i*PB +: PB] = PB'(val);
                if (k / NO == 0) acc[k % NO][i] = val;
                else             acc[k % NO][i] = clamp(acc[k % NO][i] + val, AB);
            end
            fifo_q.push_back(v);
        end
        for (int rr = 0; rr < NO; rr++) begin
            for (int i = 0; i < COL; i++) o[i*AB +: AB] = AB'(relu(acc[rr][i]));
            exp_q.push_back(o);
        end
    endtask

    task automatic wait_tiles(input int target);
        for (int c = 0; c < 3000 && tiles_done < target; c++) @(negedge clk);
        check("tiles_completed", 128'(tiles_done), 128'(target));
    endtask

    // Driver: inputs change 1 time unit after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_req > 0) begin
                reset = 1'b0;
                rst_req--;
            end else begin
                reset = 1'b1;
            end
            if (pend >= 0) pend--;
            in_dat = (pend == 0) ? pend_dat : IN_W'($urandom);
            ofifo_valid = reset && (fifo_q.size() > 0) && ($urandom_range(99) < valid_pct);
            if (bp_left > 0 && out_valid) begin
                out_ready = 1'b0;
                bp_left--;
            end else begin
                out_ready = ($urandom_range(99) < ready_pct);
            end
        end
    end

    // Monitor: samples on the falling edge, pops the FIFO model and the expected-row queue.
    initial begin
        bit exp_rd, exp_ov, done_nxt;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rst_seen) begin
                    check("rst_ofifo_rd", 128'(ofifo_rd), 128'(0));
                    check("rst_out_valid", 128'(out_valid), 128'(0));
                    check("rst_done", 128'(done), 128'(0));
                    check("rst_out", 128'(out_dat), 128'(0));
                end
                rst_seen = 1;
                fifo_q.delete();
                exp_q.delete();
                pend = -1; pops = 0; closed = 0; drained = 0; done_exp = 0; rows = 0;
            end else begin
                rst_seen = 0;
                exp_rd = ofifo_valid && (pend < 0) && !closed;
                check("ofifo_rd", 128'(ofifo_rd), 128'(exp_rd));
                exp_ov = closed && (pend < 0) && !drained;
                check("out_valid", 128'(out_valid), 128'(exp_ov));
                check("done", 128'(done), 128'(done_exp));
                if (done_exp) begin
                    closed = 0;
                    drained = 0;
                    tiles_done++;
                end
                if (ofifo_rd && fifo_q.size() > 0) begin
                    pend_dat = fifo_q.pop_front();
                    pend = RL;
                    pops++;
                    if (pops == NO * NP) begin
                        closed = 1;
                        pops = 0;
                    end
                end
                done_nxt = 0;
                if (out_valid && exp_q.size() > 0) begin
                    check("out_row", 128'(out_dat), 128'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        rows++;
                        if (rows == NO) begin
                            rows = 0;
                            drained = 1;
                            done_nxt = 1;
                        end
                    end
                end
                done_exp = done_nxt;
            end
        end
    end

    // Saturation instance: constant input per tile, acc_bw = 6, nine passes.
    initial begin
        int x [COL];
        int a;
        int srows;
        logic [S_AB*COL-1:0] e;
        repeat (3) @(posedge clk);
        #1;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < COL; i++) begin
                if (t == 0)      x[i] = 7;
                else if (t == 1) x[i] = -8;
                else             x[i] = int'($urandom_range(15)) - 8;
                s_in[i*PB +: PB] = PB'(x[i]);
                a = x[i];
                for (int k = 1; k < S_NP; k++) a = clamp(a + x[i], S_AB);
                e[i*S_AB +: S_AB] = S_AB'(relu(a));
            end
            s_reset = 1'b1;
            srows = 0;
            for (int c = 0; c < 400 && srows < NO; c++) begin
                @(negedge clk);
                if (s_ov) begin
                    check("sat_row", 128'(s_out), 128'(e));
                    srows++;
                end
            end
            check("sat_rows_seen", 128'(srows), 128'(NO));
            @(negedge clk);
            check("sat_done", 128'(s_done), 128'(1));
        end
        sat_fin = 1;
    end

    initial begin
        repeat (6) @(negedge clk);
        // Basic: +3 everywhere, full rate.
        push_tile(0, 3, 0);
        wait_tiles(1);
        // Mixed signs: -5 / +2 alternating lanes.
        push_tile(1, -5, 2);
        wait_tiles(2);
        // Starvation: FIFO often empty between pops.
        valid_pct = 30;
        push_tile(0, 3, 0);
        wait_tiles(3);
        valid_pct = 100;
        // Backpressure with the next tile already waiting upstream.
        bp_left = 5;
        push_tile(2, 0, 0);
        push_tile(2, 0, 0);
        wait_tiles(5);
        // Reset during pass 1, then a clean tile of +1.
        push_tile(2, 0, 0);
        for (int c = 0; c < 500 && !(pops == NO + 1 && pend >= 0); c++) @(negedge clk);
        check("reached_pass1", 128'(pops), 128'(NO + 1));
        rst_req = 2;
        repeat (5) @(negedge clk);
        push_tile(0, 1, 0);
        wait_tiles(6);
        // Random traffic with random stalls.
        valid_pct = 70;
        ready_pct = 60;
        for (int t = 0; t < 6; t++) push_tile(2, 0, 0);
        wait_tiles(12);
        for (int c = 0; c < 2000 && !sat_fin; c++) @(negedge clk);
        check("sat_finished", 128'(sat_fin), 128'(1));
        check("fifo_model_empty", 128'(fifo_q.size()), 128'(0));
        check("exp_queue_empty", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_accum.md
# psum_accum

Accumulator stage directly downstream of the output FIFO of the systolic MAC array. It pops one column-vector of partial sums at a time and accumulates `n_pass` kernel passes into a register buffer of `n_out` rows with per-lane saturation. It then drains the finished rows, optionally ReLU-clipped, to the next consumer (output SRAM writer) over a valid/ready handshake.

## Interface
Parameters:
- `col`, 8: lanes per vector; matches the array column count.
- `psum_bw`, 4: signed width of each incoming partial-sum lane.
- `acc_bw`, 16: signed width of each accumulator lane; must be ≥ `psum_bw`.
- `n_out`, 16: rows per tile, i.e. the number of vectors per pass.
- `n_pass`, 9: passes accumulated per tile.
- `RD_LAT`, 2: cycles from `ofifo_rd` high to valid data on `in`; must be ≥ 1.

Ports:
- `clk`  input  1  Single clock; all state updates on the rising edge.
- `reset`  input  1  Synchronous, active-low reset (asserted when 0).
- `ofifo_valid`  input  1  Upstream FIFO holds at least one vector.
- `ofifo_rd`  output  1  One-cycle pop request to upstream FIFO.
- `in`  input  psum_bw*col  Popped vector. Lane i is `[psum_bw*(i+1)-1 : psum_bw*i]`.
- `out`  output  acc_bw*col  Drained row, lane packing as for `in`.
- `out_valid`  output  1  `out` holds a finished row.
- `out_ready`  input  1  Downstream accepts `out` this cycle.
- `done`  output  1  One-cycle pulse after the last row of a tile is accepted.

## Operation
- FSM states:
  - `READ`: `ofifo_rd = ofifo_valid`. If `ofifo_valid` is high, go to `WAIT` and load the wait counter with `RD_LAT`. Otherwise stay in `READ`.
  - `WAIT`: count down. On the final cycle (counter = 1), sample `in` and write row `r`:
    - pass 0: `acc[r] = sext(in)`.
    - otherwise: `acc[r] = sat(acc[r] + sext(in))`, saturating per lane to [-2^(acc_bw-1), 2^(acc_bw-1)-1].
    - Then advance `r`. On wrap (`r = n_out-1`), advance pass `p`. If that was the last pass (`p = n_pass-1`), go to `DRAIN`; otherwise go to `READ`.
  - `DRAIN`: `out_valid` = 1 and `out` = row `d`. On `out_valid & out_ready`, advance `d`. After row `n_out-1` is accepted, go to `DONE`.
  - `DONE`: assert `done` for one cycle, clear `r`, `p` and `d`, go to `READ`.
- Only one read is outstanding at a time. `ofifo_rd` is never asserted outside `READ`, so the FIFO cannot be over-popped regardless of latency.
- `ofifo_valid` is ignored during `WAIT`, `DRAIN` and `DONE`.
- When `out_ready` is low, `out` and `out_valid` hold steady.
- Reset (`reset` = 0 at an edge), including mid-tile:
  - State returns to `READ`; `r`, `p`, `d` and the wait counter clear.
  - `ofifo_rd`, `out_valid` and `done` are 0 and `out` is 0.
  - Accumulator contents are not cleared; pass 0 overwrites them.
  - A read in flight at reset is discarded.

## Timing
- `ofifo_rd` is combinational from state and `ofifo_valid`. High in cycle t means data is sampled at the edge ending cycle t+`RD_LAT`.
- Sustained intake rate: one vector per `RD_LAT`+1 cycles.
- `out_valid` rises in the cycle after the last accumulate. With `out_ready` tied high, drain takes `n_out` cycles.
- `done` is high in the cycle after the final accept, and `READ` resumes the cycle after that.
- `out` is driven from a registered row select, so there is no combinational path from `in` to `out`.

## Configuration
- `PSUM_ACC_RELU_EN`:
  - Defined: each drained lane with its sign bit set is output as 0.
  - Undefined: the raw saturated accumulator value is output.
  - Accumulation itself is identical either way.

## Structure
- Package `psum_accum_pkg`:
  - FSM state enum (`READ`, `WAIT`, `DRAIN`, `DONE`).
  - Saturation min/max constant functions of `acc_bw`.
- Sub-module `psum_sat_add`: one lane, sign-extend plus saturating add with a pass-0 bypass select. Instantiated `col` times via generate.

## Test plan
All tests use col=8, psum_bw=4, acc_bw=16, n_out=2, n_pass=3, RD_LAT=2 unless stated.
- Basic accumulate: all lanes in = +3 for all 6 pops, `out_ready` = 1. Expect two rows, every lane 9, then a `done` pulse, and `ofifo_rd` spaced exactly 3 cycles apart.
- Negative values and ReLU:
  - Input: lanes alternate -5/+2 across all passes.
  - Macro defined: drained lanes are 0/6.
  - Macro undefined: drained lanes are -15/6 (0xFFF1/0x0006).
- Saturation: acc_bw=6, n_pass=9, lanes = +7 every pass. Output 31 in every lane; no wrap to negative.
- Backpressure: hold `out_ready` = 0 for 5 cycles during drain. Row 0 stays stable with `out_valid` high, and no `ofifo_rd` is issued even with `ofifo_valid` = 1.
- Starvation: `ofifo_valid` low between pops. `ofifo_rd` stays 0, and the result matches the basic accumulate case.
- Mid-operation reset:
  - Assert reset during pass 1 `WAIT`: all outputs are 0 the next cycle.
  - A following full tile of +1 drains as 3, with no contamination from the earlier data.
